apb_uart_master: RTL and testbench
==================================

Name: apb_uart_master

Overview:
- APB master stage sitting directly upstream of the Uart and GPIO slaves; it generates the psel/pen/pwr/pAdd/pwData bus that those slaves consume.
- Converts single-beat requests from the system side (CPU model or test sequencer) into APB SETUP/ACCESS transfers.
- Waits on pready, captures read data from the selected slave, and returns one response per request.
- Exactly one transfer is in flight at a time; there is no request queue.

Parameters:
- ADDR_W, 32, width of pAdd and req_addr.
- DATA_W, 32, width of pwData, prdata_*, req_wdata, rsp_rdata.
- TIMEOUT_CYCLES, 64, ACCESS-phase cycles allowed before abort; used only when APB_TIMEOUT_EN is defined. Must be ≥1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_sel  in  2  slave select, one-hot: 01 = GPIO, 10 = Uart.
- req_addr  in  ADDR_W  target register address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errors.
- rsp_err  out  1  qualifies rsp_valid; 1 = illegal select or timeout.
- psel  out  2  APB slave select (one-hot).
- pen  out  1  APB enable.
- pwr  out  1  APB write.
- pAdd  out  ADDR_W  APB address.
- pwData  out  DATA_W  APB write data.
- pready  in  1  ready from the selected slave (slaves' pready outputs, OR-ed externally).
- prdata_gpio  in  DATA_W  GPIO read data.
- prdata_uart  in  DATA_W  Uart read data; zero-extended externally if the slave is narrower.

Behaviour:
- All outputs are registered.
- Reset values: req_ready = 1; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0; psel = 00; pen = 0; pwr = 0; pAdd = 0; pwData = 0; state = IDLE.
- States:
  - IDLE: req_ready = 1.
  - SETUP: req_ready = 0.
  - ACCESS: req_ready = 0.
- IDLE, handshake: a request is accepted on an edge where req_valid & req_ready.
  - Legal select (01 or 10): latch req_write/req_addr/req_wdata/req_sel into pwr/pAdd/pwData/psel at that edge; pen = 0; go to SETUP.
  - Illegal select (00 or 11): no APB activity. Next cycle: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; stay in IDLE.
- SETUP: lasts exactly 1 cycle. Next edge: pen = 1, go to ACCESS.
- ACCESS: psel, pwr, pAdd, pwData and pen are held stable. At an edge where pready = 1:
  - Capture rsp_rdata = prdata of the selected slave on reads, 0 on writes.
  - rsp_valid = 1, rsp_err = 0.
  - psel = 00, pen = 0, pwr = 0; pAdd and pwData keep their last values.
  - Go to IDLE with req_ready = 1.
- Latency: acceptance at edge k → psel visible from k+1 → pen from k+2. With pready = 1 throughout ACCESS, rsp_valid is high in cycle k+3. Each pready = 0 cycle adds one cycle.
- Back-to-back: a new request may be accepted in the same cycle rsp_valid is high. Minimum issue interval is 3 cycles.
- rsp_valid is high for exactly one cycle per accepted request. There is no response backpressure; the consumer must always accept.
- pready is ignored outside ACCESS.
- Reset mid-transfer (any state): at the reset edge all outputs return to their reset values and state = IDLE; no response is produced for the aborted request.
- Requests presented while req_ready = 0 are not latched; the requester holds them until accepted.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready = 0.
  - When the counter reaches TIMEOUT_CYCLES, the transfer is aborted: psel = 00, pen = 0, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, state = IDLE.
  - If pready = 1 on the same edge the limit is reached, pready wins and the transfer completes normally with rsp_err = 0.
- Not defined: no counter exists; ACCESS waits indefinitely for pready; rsp_err is set only by an illegal select.

Test Plan:
- Reset: hold rst = 1 for 2 cycles → all outputs at reset values, req_ready = 1.
- Uart read: req_sel = 10, req_addr = 15, read, pready = 1, prdata_uart = 0x5A → psel = 10 and pAdd = 15 at k+1; pen = 1 at k+2; rsp_valid with rsp_rdata = 0x5A, rsp_err = 0 at k+3.
- GPIO write with wait states: req_sel = 01, req_addr = 4, req_wdata = 0xA5, pready low for 3 ACCESS cycles → pwr = 1, pwData = 0xA5 held stable throughout; rsp_valid at k+6, rsp_rdata = 0.
- Illegal select: req_sel = 11 → psel stays 00, pen stays 0; rsp_valid = 1, rsp_err = 1 in the cycle after acceptance.
- Back-to-back plus mid-transfer reset: second request presented during rsp_valid is accepted at that edge; rst asserted during its ACCESS → psel = 00 and pen = 0 next cycle, no rsp_valid.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES = 4: pready held 0 → rsp_err = 1 after 4 ACCESS cycles, psel = 00. Without the macro → still in ACCESS after 100 cycles.

Source files
------------

// File: rtl/apb_uart_master.sv
// APB master for the Uart/GPIO slaves: one single-beat request in flight at a time.
// Optional ACCESS-phase timeout abort is compiled in when APB_TIMEOUT_EN is defined.
module apb_uart_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_sel,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        psel,
    output logic              pen,
    output logic              pwr,
    output logic [ADDR_W-1:0] pAdd,
    output logic [DATA_W-1:0] pwData,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata_gpio,
    input  logic [DATA_W-1:0] prdata_uart
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t              state_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [1:0]          psel_q;
    logic                pen_q;
    logic                pwr_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;

    logic                sel_legal_d;
    logic [DATA_W-1:0]   rdata_d;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             to_hit_d;

    assign to_hit_d = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    assign sel_legal_d = (req_sel == 2'b01) || (req_sel == 2'b10);

    always_comb begin
        rdata_d = '0;
        unique case (1'b1)
            psel_q[0]: rdata_d = prdata_gpio;
            psel_q[1]: rdata_d = prdata_uart;
            default:   rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            psel_q      <= 2'b00;
            pen_q       <= 1'b0;
            pwr_q       <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        if (sel_legal_d) begin
                            psel_q      <= req_sel;
                            pwr_q       <= req_write;
                            paddr_q     <= req_addr;
                            pwdata_q    <= req_wdata;
                            pen_q       <= 1'b0;
                            req_ready_q <= 1'b0;
                            state_q     <= SETUP;
                        end else begin
                            // Bad select never reaches the bus; answer immediately.
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                SETUP: begin
                    pen_q   <= 1'b1;
                    state_q <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwr_q ? '0 : rdata_d;
                        psel_q      <= 2'b00;
                        pen_q       <= 1'b0;
                        pwr_q       <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (to_hit_d) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        psel_q      <= 2'b00;
                        pen_q       <= 1'b0;
                        pwr_q       <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign psel      = psel_q;
    assign pen       = pen_q;
    assign pwr       = pwr_q;
    assign pAdd      = paddr_q;
    assign pwData    = pwdata_q;

endmodule

// File: tb/tb_apb_uart_master.sv
// Self-checking bench for apb_uart_master: per-scenario tasks plus a response scoreboard.
// Build with +define+APB_TIMEOUT_EN to exercise the timeout abort path.
module tb_apb_uart_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_sel = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  psel;
    logic        pen;
    logic        pwr;
    logic [31:0] pAdd;
    logic [31:0] pwData;
    logic        pready = 1'b0;
    logic [31:0] prdata_gpio = '0;
    logic [31:0] prdata_uart = '0;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];

    apb_uart_master #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_sel(req_sel),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .psel(psel),
        .pen(pen),
        .pwr(pwr),
        .pAdd(pAdd),
        .pwData(pwData),
        .pready(pready),
        .prdata_gpio(prdata_gpio),
        .prdata_uart(prdata_uart)
    );

    always #5 clk = ~clk;

    // Scoreboard: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rsp_t e;
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: rsp got rdata=%h err=%b, required no response",
                         rsp_rdata, rsp_err);
            end else begin
                e = sb.pop_front();
                if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                    fails++;
                    $display("FAIL sb_rsp: got rdata=%h err=%b, required rdata=%h err=%b",
                             rsp_rdata, rsp_err, e.rdata, e.err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic wr, input logic [1:0] sel,
                           input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_write = wr;
        req_sel   = sel;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b required 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL rst_rsp_err: got %b required 0", rsp_err); end
        checks++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata: got %h required 0", rsp_rdata); end
        checks++; if (psel !== 2'b00) begin fails++; $display("FAIL rst_psel: got %b required 00", psel); end
        checks++; if (pen !== 1'b0 || pwr !== 1'b0) begin fails++; $display("FAIL rst_pen_pwr: got %b%b required 00", pen, pwr); end
        checks++; if (pAdd !== 32'h0 || pwData !== 32'h0) begin fails++; $display("FAIL rst_addr_data: got %h/%h required 0/0", pAdd, pwData); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_uart_read();
        present(1'b0, 2'b10, 32'd15, 32'h0);
        pready = 1'b1;
        prdata_uart = 32'h5A;
        prdata_gpio = 32'hDEAD;
        sb.push_back('{rdata: 32'h5A, err: 1'b0});
        tick();
        req_valid = 1'b0;
        checks++; if (psel !== 2'b10 || pAdd !== 32'd15) begin fails++; $display("FAIL rd_setup: got psel=%b pAdd=%0d required 10/15", psel, pAdd); end
        checks++; if (pen !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("FAIL rd_setup_pen: got pen=%b rdy=%b required 0/0", pen, req_ready); end
        tick();
        checks++; if (pen !== 1'b1 || psel !== 2'b10 || pwr !== 1'b0) begin fails++; $display("FAIL rd_access: got pen=%b psel=%b pwr=%b required 1/10/0", pen, psel, pwr); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5A || rsp_err !== 1'b0) begin fails++; $display("FAIL rd_rsp: got v=%b d=%h e=%b required 1/5a/0", rsp_valid, rsp_rdata, rsp_err); end
        checks++; if (psel !== 2'b00 || pen !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL rd_done: got psel=%b pen=%b rdy=%b required 00/0/1", psel, pen, req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_pulse: got %b required 0", rsp_valid); end
    endtask

    task automatic test_gpio_write_wait();
        present(1'b1, 2'b01, 32'd4, 32'hA5);
        pready = 1'b0;
        prdata_gpio = 32'h77;
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (pwr !== 1'b1 || pwData !== 32'hA5 || psel !== 2'b01 || pAdd !== 32'd4 || rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL wr_hold_c%0d: got pwr=%b d=%h psel=%b a=%0d v=%b required 1/a5/01/4/0",
                         c, pwr, pwData, psel, pAdd, rsp_valid);
            end
            checks++;
            if (pen !== (c >= 2)) begin fails++; $display("FAIL wr_pen_c%0d: got %b required %b", c, pen, c >= 2); end
            if (c == 5) pready = 1'b1;
            tick();
        end
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin fails++; $display("FAIL wr_rsp: got v=%b d=%h e=%b required 1/0/0", rsp_valid, rsp_rdata, rsp_err); end
        checks++; if (psel !== 2'b00 || pwr !== 1'b0 || pwData !== 32'hA5) begin fails++; $display("FAIL wr_done: got psel=%b pwr=%b d=%h required 00/0/a5", psel, pwr, pwData); end
        tick();
    endtask

    task automatic test_illegal_sel();
        logic [1:0] bad[2];
        bad[0] = 2'b11;
        bad[1] = 2'b00;
        pready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            present(1'b0, bad[i], 32'h20, 32'h0);
            sb.push_back('{rdata: 32'h0, err: 1'b1});
            tick();
            req_valid = 1'b0;
            checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin fails++; $display("FAIL ill_rsp_%0d: got v=%b e=%b d=%h required 1/1/0", i, rsp_valid, rsp_err, rsp_rdata); end
            checks++; if (psel !== 2'b00 || pen !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL ill_bus_%0d: got psel=%b pen=%b rdy=%b required 00/0/1", i, psel, pen, req_ready); end
            tick();
        end
    endtask

    task automatic test_back_to_back_reset();
        present(1'b0, 2'b10, 32'h8, 32'h0);
        pready = 1'b1;
        prdata_uart = 32'h33;
        sb.push_back('{rdata: 32'h33, err: 1'b0});
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b1) begin fails++; $display("FAIL b2b_first: got v=%b rdy=%b required 1/1", rsp_valid, req_ready); end
        present(1'b0, 2'b01, 32'hC, 32'h0);
        pready = 1'b0;
        tick();
        req_valid = 1'b0;
        checks++; if (psel !== 2'b01 || pAdd !== 32'hC) begin fails++; $display("FAIL b2b_accept: got psel=%b a=%h required 01/c", psel, pAdd); end
        tick();
        checks++; if (pen !== 1'b1) begin fails++; $display("FAIL b2b_access: got pen=%b required 1", pen); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (psel !== 2'b00 || pen !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL b2b_reset: got psel=%b pen=%b v=%b rdy=%b required 00/0/0/1", psel, pen, rsp_valid, req_ready); end
        pready = 1'b1;
        repeat (4) tick();
        checks++; if (psel !== 2'b00) begin fails++; $display("FAIL b2b_idle: got psel=%b required 00", psel); end
    endtask

    task automatic test_timeout();
        int n;
        present(1'b0, 2'b01, 32'h10, 32'h0);
        pready = 1'b0;
        prdata_gpio = 32'h99;
`ifdef APB_TIMEOUT_EN
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        tick();
        req_valid = 1'b0;
        n = 1;
        while (rsp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL to_expire: no response within %0d cycles, required one at cycle 6", n); end
        checks++; if (n !== 6) begin fails++; $display("FAIL to_latency: got cycle %0d required 6", n); end
        checks++; if (rsp_err !== 1'b1 || psel !== 2'b00 || pen !== 1'b0) begin fails++; $display("FAIL to_abort: got e=%b psel=%b pen=%b required 1/00/0", rsp_err, psel, pen); end
        tick();
`else
        tick();
        req_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (rsp_valid === 1'b1) n++;
            tick();
        end
        checks++; if (n !== 0) begin fails++; $display("FAIL nto_rsp: got %0d responses required 0", n); end
        checks++; if (psel !== 2'b01 || pen !== 1'b1 || req_ready !== 1'b0) begin fails++; $display("FAIL nto_hold: got psel=%b pen=%b rdy=%b required 01/1/0", psel, pen, req_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_uart_read();
        test_gpio_write_wait();
        test_illegal_sel();
        test_back_to_back_reset();
        test_timeout();
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d pending responses required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
